// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> ACCESS -> DONE with store lane alignment, load
// extension and ack timeout. Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              flush,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        write_enable,
    input  logic [4:0]        read_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [1:0]        dbg_state_o
);

    // Memory handshake: dmem_req rises on entry to ACCESS and stays high, with we/be/addr/wdata
    // held constant, until the cycle dmem_ack is seen; dmem_ack in any other state is ignored.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                latch, capture, start, misalign;
    logic [2:0]          ld_type_in, ld_q;
    logic [ADDR_W-3:0]   waddr_q;
    logic [1:0]          off_q;
    logic                we_q;
    logic [3:0]          be_q, st_be;
    logic [DATA_W-1:0]   wdata_q, st_data, rdata_raw_q, ld_word, ld_ext;
    logic                in_access, in_done;

    assign start   = mem_valid & ~flush & (mem_read | mem_write);
    assign st_be   = write_enable << addr[1:0];
    assign st_data = wdata << {addr[1:0], 3'b000};

    // Zero or multi-hot read_enable falls back to a full-word load.
    always_comb begin
        ld_type_in = LD_W;
        case (read_enable)
            5'b00001: ld_type_in = LD_B;
            5'b00010: ld_type_in = LD_H;
            5'b01000: ld_type_in = LD_BU;
            5'b10000: ld_type_in = LD_HU;
            default:  ld_type_in = LD_W;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic is_half, is_word;
    assign is_half  = mem_write ? (write_enable == 4'b0011)
                                : (ld_type_in == LD_H || ld_type_in == LD_HU);
    assign is_word  = mem_write ? (write_enable == 4'b1111) : (ld_type_in == LD_W);
    assign misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    cnt_d = '0;
                    err_d = misalign;
                    state_d = misalign ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    capture = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (TIMEOUT > 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q     <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            ld_q        <= LD_W;
            rdata_raw_q <= '0;
        end else begin
            if (latch) begin
                waddr_q <= addr[ADDR_W-1:2];
                off_q   <= addr[1:0];
                we_q    <= mem_write;
                be_q    <= mem_write ? st_be : 4'b1111;
                wdata_q <= mem_write ? st_data : '0;
                ld_q    <= ld_type_in;
            end
            if (capture) begin
                rdata_raw_q <= dmem_rdata;
            end
        end
    end

    assign ld_word = rdata_raw_q >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_word;
        case (ld_q)
            LD_B:    ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            LD_H:    ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            LD_BU:   ld_ext = {24'd0, ld_word[7:0]};
            LD_HU:   ld_ext = {16'd0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    assign in_access   = (state_q == S_ACCESS);
    assign in_done     = (state_q == S_DONE);
    assign stall       = ((state_q == S_IDLE) && start) || in_access;
    assign dmem_req    = in_access;
    assign dmem_we     = in_access & we_q;
    assign dmem_be     = in_access ? be_q : 4'b0000;
    assign dmem_addr   = in_access ? {waddr_q, 2'b00} : '0;
    assign dmem_wdata  = in_access ? wdata_q : '0;
    assign err         = in_done & err_q;
    assign rdata_valid = in_done & ~we_q & ~err_q;
    assign rdata       = rdata_valid ? ld_ext : '0;
    assign dbg_state_o = state_q;

endmodule
